// File: rtl/mux16_scan_pkg.sv
// rtl/mux16_scan_pkg.sv - shared widths and FSM state encoding for the 16:1 scan serializer
package mux16_scan_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

endpackage

// File: rtl/mux_16cross1.sv
// rtl/mux_16cross1.sv - 16:1 bit multiplexer, y = data[sel]
module mux_16cross1
   import mux16_scan_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [SEL_W-1:0]  sel,
   output logic              y
);

   assign y = data[sel];

endmodule

// File: rtl/mux16_scan_ctrl.sv
// rtl/mux16_scan_ctrl.sv - serializes a 16-bit word one bit per beat through mux_16cross1
// Define SCAN_PARITY_EN to append an XOR parity beat after the 16 data beats.
module mux16_scan_ctrl
   import mux16_scan_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_last,
   output logic [SEL_W-1:0]  sel_out
);

   localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? {SEL_W{1'b1}} : '0;
   localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : {SEL_W{1'b1}};

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                y;
   logic                at_last;
   logic                beat;

   mux_16cross1 u_mux (
      .data (data_q),
      .sel  (sel_q),
      .y    (y)
   );

   assign at_last = (sel_q == SEL_LAST);
   assign beat    = ser_valid & ser_ready;
   assign sel_out = sel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   // sel stops on the last position; it is only reloaded by the next accept
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               sel_d   = SEL_FIRST;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (beat) begin
               if (at_last) begin
`ifdef SCAN_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
`endif
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - SEL_W'(1);
               end else begin
                  sel_d = sel_q + SEL_W'(1);
               end
            end
         end
`ifdef SCAN_PARITY_EN
         PARITY: begin
            if (beat) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_last  = 1'b0;
      ser_out   = y;
      case (state_q)
         IDLE: in_ready = 1'b1;
         SHIFT: begin
            ser_valid = 1'b1;
`ifndef SCAN_PARITY_EN
            ser_last  = at_last;
`endif
         end
`ifdef SCAN_PARITY_EN
         PARITY: begin
            ser_valid = 1'b1;
            ser_last  = 1'b1;
            ser_out   = ^data_q;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb/tb_mux16_scan_ctrl.sv - self-checking bench, LSB-first and MSB-first instances driven in lockstep
module tb_mux16_scan_ctrl;

`ifdef SCAN_PARITY_EN
   localparam int NBEATS = 17;
`else
   localparam int NBEATS = 16;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        ser_ready;

   logic        in_ready0, ser_out0, ser_valid0, ser_last0;
   logic [3:0]  sel_out0;
   logic        in_ready1, ser_out1, ser_valid1, ser_last1;
   logic [3:0]  sel_out1;

   int checks = 0;
   int errors = 0;

   logic [15:0] s0, s1;
   logic        p0, p1;

   always #5 clk = ~clk;

   mux16_scan_ctrl #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
      .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_last(ser_last0),
      .sel_out(sel_out0)
   );

   mux16_scan_ctrl #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
      .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_last(ser_last1),
      .sel_out(sel_out1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: beat k of a word carries bit k (LSB first) or bit 15-k (MSB first); beat 16 is parity
   function automatic logic exp_bit(input logic [15:0] w, input int k, input bit msb);
      if (k >= 16) return ^w;
      return msb ? w[15-k] : w[k];
   endfunction

   function automatic logic [3:0] exp_sel(input int k, input bit msb);
      int i;
      i = (k > 15) ? 15 : k;
      return msb ? 4'(15 - i) : 4'(i);
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready0"}, 16'(in_ready0), 16'd1);
      chk({tag, "_in_ready1"}, 16'(in_ready1), 16'd1);
      chk({tag, "_ser_valid0"}, 16'(ser_valid0), 16'd0);
      chk({tag, "_ser_valid1"}, 16'(ser_valid1), 16'd0);
      chk({tag, "_ser_last0"}, 16'(ser_last0), 16'd0);
      chk({tag, "_sel_out0"}, 16'(sel_out0), 16'd0);
      chk({tag, "_sel_out1"}, 16'(sel_out1), 16'd0);
      chk({tag, "_ser_out0"}, 16'(ser_out0), 16'd0);
      chk({tag, "_ser_out1"}, 16'(ser_out1), 16'd0);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk({tag, "_in_ready0"}, 16'(in_ready0), 16'd1);
      chk({tag, "_in_ready1"}, 16'(in_ready1), 16'd1);
      chk({tag, "_ser_valid0"}, 16'(ser_valid0), 16'd0);
      chk({tag, "_ser_last1"}, 16'(ser_last1), 16'd0);
   endtask

   // mode 0: ser_ready always high, mode 1: random backpressure
   task automatic run_word(input logic [15:0] w, input int mode, input int stall_at,
                           input int abort_at, input logic hold, input logic [15:0] next_w,
                           output logic [15:0] o0, output logic [15:0] o1,
                           output logic op0, output logic op1);
      int   k;
      int   cyc;
      int   stalls;
      logic rdy;
      o0 = '0; o1 = '0; op0 = 1'b0; op1 = 1'b0;
      @(negedge clk);
      chk("accept_in_ready0", 16'(in_ready0), 16'd1);
      chk("accept_in_ready1", 16'(in_ready1), 16'd1);
      in_data   = w;
      in_valid  = 1'b1;
      ser_ready = 1'($urandom);
      k = 0; cyc = 0; stalls = 0;
      while (k < NBEATS) begin
         @(negedge clk);
         in_valid = hold;
         in_data  = hold ? next_w : 16'($urandom);
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("abort");
            @(negedge clk);
            check_reset_outputs("abort_hold");
            rst = 1'b0;
            return;
         end
         cyc++;
         if (cyc > 200) begin
            errors++;
            $error("FAIL word_timeout observed=%0d beats expected=%0d", k, NBEATS);
            return;
         end
         chk("ser_valid0", 16'(ser_valid0), 16'd1);
         chk("ser_valid1", 16'(ser_valid1), 16'd1);
         chk("ser_out0", 16'(ser_out0), 16'(exp_bit(w, k, 1'b0)));
         chk("ser_out1", 16'(ser_out1), 16'(exp_bit(w, k, 1'b1)));
         chk("sel_out0", 16'(sel_out0), 16'(exp_sel(k, 1'b0)));
         chk("sel_out1", 16'(sel_out1), 16'(exp_sel(k, 1'b1)));
         chk("ser_last0", 16'(ser_last0), 16'(k == NBEATS - 1));
         chk("ser_last1", 16'(ser_last1), 16'(k == NBEATS - 1));
         chk("busy_in_ready0", 16'(in_ready0), 16'd0);
         rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (k == stall_at && stalls < 3) begin
            rdy = 1'b0;
            stalls++;
         end
         ser_ready = rdy;
         if (rdy) begin
            if (k < 16) begin
               o0[k] = ser_out0;
               o1    = {o1[14:0], ser_out1};
            end else begin
               op0 = ser_out0;
               op1 = ser_out1;
            end
            k++;
         end
      end
   endtask

   initial begin
      logic [15:0] w;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      ser_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      run_word(16'hB5C3, 0, -1, -1, 1'b0, 16'h0, s0, s1, p0, p1);
      chk("lsb_stream_b5c3", s0, 16'hB5C3);
      chk("msb_stream_b5c3", s1, 16'hB5C3);
`ifdef SCAN_PARITY_EN
      chk("parity0_b5c3", 16'(p0), 16'd1);
      chk("parity1_b5c3", 16'(p1), 16'd1);
`endif
      check_idle("after_b5c3");

      run_word(16'hB5C3, 0, 5, -1, 1'b0, 16'h0, s0, s1, p0, p1);
      chk("stall_stream0", s0, 16'hB5C3);
      chk("stall_stream1", s1, 16'hB5C3);

      run_word(16'hB5C3, 0, -1, 7, 1'b0, 16'h0, s0, s1, p0, p1);
      run_word(16'hFFFF, 0, -1, -1, 1'b0, 16'h0, s0, s1, p0, p1);
      chk("post_reset_ffff0", s0, 16'hFFFF);
      chk("post_reset_ffff1", s1, 16'hFFFF);

      run_word(16'h0001, 0, -1, -1, 1'b1, 16'h8000, s0, s1, p0, p1);
      chk("held_valid_w1_0", s0, 16'h0001);
      chk("held_valid_w1_1", s1, 16'h0001);
      run_word(16'h8000, 0, -1, -1, 1'b0, 16'h0, s0, s1, p0, p1);
      chk("held_valid_w2_0", s0, 16'h8000);
      chk("held_valid_w2_1", s1, 16'h8000);

      for (int n = 0; n < 24; n++) begin
         w = 16'($urandom);
         run_word(w, 1, -1, -1, 1'b0, 16'h0, s0, s1, p0, p1);
         chk("rand_stream0", s0, w);
         chk("rand_stream1", s1, w);
`ifdef SCAN_PARITY_EN
         chk("rand_parity0", 16'(p0), 16'(^w));
`endif
      end
      check_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/mux16_scan_ctrl.md
MUX16_SCAN_CTRL -- requirements
Module: mux16_scan_ctrl

Interface
REQ-001 Parameter: MSB_FIRST, 0, bit order: 0 = sel counts 0..15; 1 = sel counts 15..0.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: in_data  input  16  parallel word to serialize.
REQ-005 Port: in_valid  input  1  in_data valid.
REQ-006 Port: in_ready  output  1  block can accept a word.
REQ-007 Port: ser_out  output  1  current serial bit, equal to the mux output y.
REQ-008 Port: ser_valid  output  1  ser_out valid.
REQ-009 Port: ser_ready  input  1  downstream accepts ser_out.
REQ-010 Port: ser_last  output  1  final beat of the current word.
REQ-011 Port: sel_out  output  4  current mux select, for observation.

Function
REQ-012 States: IDLE, SHIFT, and PARITY when SCAN_PARITY_EN is defined.
REQ-013 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-014 On accept: in_data captured into data_reg; sel set to 0 (MSB_FIRST=0) or 15 (MSB_FIRST=1); go to SHIFT.
REQ-015 In SHIFT: ser_valid=1 and ser_out=data_reg[sel], combinational through the mux from registered data_reg and sel; first bit valid the cycle after accept.
REQ-016 Beat = ser_valid & ser_ready; each beat advances sel by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
REQ-017 With ser_ready=0: ser_out, sel_out, ser_last and ser_valid SHALL hold stable.
REQ-018 ser_last=1 on the beat at sel=15 (MSB_FIRST=0) or sel=0 (MSB_FIRST=1) when parity is compiled out; on the PARITY beat when it is compiled in.
REQ-019 Final beat returns the FSM to IDLE; sel never wraps inside a word.
REQ-020 Minimum word period: 17 cycles (18 with parity), accept cycle included; no accept during SHIFT/PARITY.
REQ-021 In IDLE: ser_valid=0, ser_last=0; ser_out follows the mux and is don't-care.
REQ-022 in_data changes after accept SHALL NOT affect the word in flight.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, data_reg=16'h0000, sel=0; outputs in_ready=1, ser_valid=0, ser_last=0, sel_out=0, ser_out=0.
REQ-024 Reset mid-word SHALL discard the word; no further beats after rst asserts.
REQ-025 First accept is possible on the first clock edge after rst deasserts.

Configuration
REQ-026 Macro SCAN_PARITY_EN defined: after the 16th data beat, PARITY state drives ser_out = XOR of data_reg with ser_valid=1 and ser_last=1; sel_out holds its last value.
REQ-027 Macro SCAN_PARITY_EN undefined: no PARITY state; words are exactly 16 beats.

Structure
REQ-028 Package mux16_scan_pkg: DATA_W=16, SEL_W=4, state encodings IDLE/SHIFT/PARITY.
REQ-029 Exactly one sub-module: mux_16cross1 (data, sel, y), fed by data_reg and sel; ser_out = y.
REQ-030 No other combinational path from in_data to ser_out.

Verification
REQ-031 MSB_FIRST=0, ser_ready=1, in_data=16'hB5C3 -> ser_out beats 1,1,0,0,0,0,1,1,1,0,1,0,1,1,0,1; ser_last on beat 16; in_ready high again the next cycle.
REQ-032 MSB_FIRST=1, in_data=16'hB5C3 -> beats 1,0,1,1,0,1,0,1,1,1,0,0,0,0,1,1; sel_out steps 15 down to 0.
REQ-033 ser_ready held low for 3 cycles at sel=5 (MSB_FIRST=0, 16'hB5C3) -> ser_out=0 and sel_out=5 stable for all 3 cycles, then the sequence resumes unchanged.
REQ-034 rst pulsed at beat 7 -> ser_valid=0 immediately; in_ready=1; the next word 16'hFFFF serializes as 16 ones.
REQ-035 SCAN_PARITY_EN defined, in_data=16'hB5C3 -> 17 beats; beat 17 ser_out=1 (popcount 9) with ser_last=1.
REQ-036 in_valid held high with words 16'h0001 then 16'h8000 -> second word accepted only after the first word's last beat; beat streams 1 then 15 zeros, and 15 zeros then 1.
